// File: rtl/pipe_hazard_sched_if.sv
// Hazard scheduler handshake bundle: hazard/memory indications from the
// pipeline (master) and pipeline-register enables back from the scheduler (slave).
interface pipe_hazard_sched_if;
  logic       load_depen;
  logic       ctrl_xfer;
  logic       dmem_req;
  logic       dmem_ack;
  logic       wpcir;
  logic       id_bubble;
  logic       if_annul;
  logic       pipe_hold;
  logic       mem_timeout;
  logic [1:0] sched_state;

  modport master (
    output load_depen, ctrl_xfer, dmem_req, dmem_ack,
    input  wpcir, id_bubble, if_annul, pipe_hold, mem_timeout, sched_state
  );

  modport slave (
    input  load_depen, ctrl_xfer, dmem_req, dmem_ack,
    output wpcir, id_bubble, if_annul, pipe_hold, mem_timeout, sched_state
  );
endinterface

// File: rtl/pipe_hazard_sched.sv
// Pipeline hazard scheduler for the 5-stage CPU.
// Sequences PC/IF-ID write enable, ID/EX bubble, IF/ID annul and back-end hold
// from load-use, control-transfer and data-memory handshake indications.
// Outputs are Mealy: decoded from current state and same-cycle inputs.
// Optional feature macro: HAZ_PERF_EN adds stall_cycles / annul_count counters.
//
// state | meaning
// RUN   | normal flow, hazards decoded combinationally
// LDSTL | extra load-use stall cycles (ldcnt remaining)
// MWAIT | back end frozen waiting for dmem_ack (wcnt cycles waited)
// ERR   | memory timed out, frozen until reset
module pipe_hazard_sched #(
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned MAX_WAIT   = 16,
  parameter int unsigned DELAY_SLOT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_sched_if.slave   hz
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [15:0]          annul_count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    LDSTL = 2'b01,
    MWAIT = 2'b10,
    ERR   = 2'b11
  } state_t;

  localparam logic [2:0] LAT_M1    = 3'(LOAD_LAT - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state;
  logic [2:0] ldcnt;
  logic [7:0] wcnt;
  logic       mem_timeout_q;

  logic mem_stall;
  logic wpcir_c, bubble_c, annul_c, hold_c;

  assign mem_stall = hz.dmem_req & ~hz.dmem_ack;

  // Mealy enable decode; memory wait outranks load stall outranks transfer
  always_comb begin
    wpcir_c  = 1'b1;
    bubble_c = 1'b0;
    annul_c  = 1'b0;
    hold_c   = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          hold_c  = 1'b1;
          wpcir_c = 1'b0;
        end else if (hz.load_depen) begin
          wpcir_c  = 1'b0;
          bubble_c = 1'b1;
        end else if (hz.ctrl_xfer && (DELAY_SLOT == 0)) begin
          annul_c = 1'b1;
        end
      end
      LDSTL: begin
        if (mem_stall) begin
          hold_c  = 1'b1;
          wpcir_c = 1'b0;
        end else begin
          wpcir_c  = 1'b0;
          bubble_c = 1'b1;
        end
      end
      default: begin
        hold_c  = 1'b1;
        wpcir_c = 1'b0;
      end
    endcase
  end

  // State and counter sequencing; ldcnt is frozen across a memory wait
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      ldcnt         <= 3'd0;
      wcnt          <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state <= MWAIT;
            wcnt  <= 8'd1;
          end else if (hz.load_depen && (LOAD_LAT > 1)) begin
            state <= LDSTL;
            ldcnt <= LAT_M1;
          end
        end
        LDSTL: begin
          if (mem_stall) begin
            state <= MWAIT;
            wcnt  <= 8'd1;
          end else if (ldcnt <= 3'd1) begin
            state <= RUN;
            ldcnt <= 3'd0;
          end else begin
            ldcnt <= ldcnt - 3'd1;
          end
        end
        MWAIT: begin
          if (hz.dmem_ack) begin
            wcnt  <= 8'd0;
            state <= (ldcnt != 3'd0) ? LDSTL : RUN;
          end else if (wcnt >= WAIT_LAST) begin
            state         <= ERR;
            mem_timeout_q <= 1'b1;
          end else if (wcnt != 8'hFF) begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: begin
          state         <= ERR;
          mem_timeout_q <= 1'b1;
        end
      endcase
    end
  end

  assign hz.wpcir       = wpcir_c;
  assign hz.id_bubble   = bubble_c;
  assign hz.if_annul    = annul_c;
  assign hz.pipe_hold   = hold_c;
  assign hz.mem_timeout = mem_timeout_q;
  assign hz.sched_state = state;

`ifdef HAZ_PERF_EN
  // Free-running wrap-around performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      annul_count  <= 16'd0;
    end else begin
      if (!wpcir_c) stall_cycles <= stall_cycles + 32'd1;
      if (annul_c)  annul_count  <= annul_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Directed bench for pipe_hazard_sched: three instances with different
// parameter sets share one stimulus; each scenario checks the relevant one.
module tb_pipe_hazard_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_depen = 1'b0, ctrl_xfer = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_sched_if if_a ();
  pipe_hazard_sched_if if_b ();
  pipe_hazard_sched_if if_c ();

  assign if_a.load_depen = load_depen;
  assign if_a.ctrl_xfer  = ctrl_xfer;
  assign if_a.dmem_req   = dmem_req;
  assign if_a.dmem_ack   = dmem_ack;
  assign if_b.load_depen = load_depen;
  assign if_b.ctrl_xfer  = ctrl_xfer;
  assign if_b.dmem_req   = dmem_req;
  assign if_b.dmem_ack   = dmem_ack;
  assign if_c.load_depen = load_depen;
  assign if_c.ctrl_xfer  = ctrl_xfer;
  assign if_c.dmem_req   = dmem_req;
  assign if_c.dmem_ack   = dmem_ack;

`ifdef HAZ_PERF_EN
  logic [31:0] sc_a, sc_b, sc_c;
  logic [15:0] ac_a, ac_b, ac_c;
`endif

  pipe_hazard_sched #(.LOAD_LAT(1), .MAX_WAIT(4), .DELAY_SLOT(0)) u_a (
    .clk(clk), .rst(rst), .hz(if_a.slave)
`ifdef HAZ_PERF_EN
    , .stall_cycles(sc_a), .annul_count(ac_a)
`endif
  );
  pipe_hazard_sched #(.LOAD_LAT(2), .MAX_WAIT(16), .DELAY_SLOT(1)) u_b (
    .clk(clk), .rst(rst), .hz(if_b.slave)
`ifdef HAZ_PERF_EN
    , .stall_cycles(sc_b), .annul_count(ac_b)
`endif
  );
  pipe_hazard_sched #(.LOAD_LAT(3), .MAX_WAIT(16), .DELAY_SLOT(1)) u_c (
    .clk(clk), .rst(rst), .hz(if_c.slave)
`ifdef HAZ_PERF_EN
    , .stall_cycles(sc_c), .annul_count(ac_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge; inputs change here
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ld, input logic cx, input logic rq, input logic ak);
    load_depen = ld;
    ctrl_xfer  = cx;
    dmem_req   = rq;
    dmem_ack   = ak;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // scenario 6 vectors (LOAD_LAT=3 instance)
  logic [0:5] v_ld   = 6'b100000;
  logic [0:5] v_rq   = 6'b011000;
  logic [0:5] v_ak   = 6'b001000;
  logic [0:5] e_wp   = 6'b000001;
  logic [0:5] e_hold = 6'b011000;
  logic [0:5] e_bub  = 6'b100110;
  logic [1:0] e_st [0:5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00};

  initial begin
    int stalls;

    // 1: reset state
    do_reset();
    #1;
    chk("rst_wpcir",   32'(if_a.wpcir), 32'd1);
    chk("rst_bubble",  32'(if_a.id_bubble), 32'd0);
    chk("rst_annul",   32'(if_a.if_annul), 32'd0);
    chk("rst_hold",    32'(if_a.pipe_hold), 32'd0);
    chk("rst_timeout", 32'(if_a.mem_timeout), 32'd0);
    chk("rst_state",   32'(if_a.sched_state), 32'd0);

    // 2: LOAD_LAT=2 stall lasts exactly 2 cycles
    set_in(1, 0, 0, 0);
    #1;
    chk("ld2_c0_wpcir",  32'(if_b.wpcir), 32'd0);
    chk("ld2_c0_bubble", 32'(if_b.id_bubble), 32'd1);
    chk("ld1_c0_bubble", 32'(if_a.id_bubble), 32'd1);
    cyc();
    set_in(0, 0, 0, 0);
    #1;
    chk("ld2_c1_wpcir",  32'(if_b.wpcir), 32'd0);
    chk("ld2_c1_bubble", 32'(if_b.id_bubble), 32'd1);
    chk("ld2_c1_state",  32'(if_b.sched_state), 32'd1);
    chk("ld1_c1_wpcir",  32'(if_a.wpcir), 32'd1);
    cyc();
    #1;
    chk("ld2_c2_wpcir",  32'(if_b.wpcir), 32'd1);
    chk("ld2_c2_bubble", 32'(if_b.id_bubble), 32'd0);
    chk("ld2_c2_state",  32'(if_b.sched_state), 32'd0);

    // 3: load stall outranks transfer; then annul with DELAY_SLOT=0 only
    do_reset();
    set_in(1, 1, 0, 0);
    #1;
    chk("xf_ld_bubble", 32'(if_a.id_bubble), 32'd1);
    chk("xf_ld_annul",  32'(if_a.if_annul), 32'd0);
    chk("xf_ld_wpcir",  32'(if_a.wpcir), 32'd0);
    cyc();
    set_in(0, 1, 0, 0);
    #1;
    chk("xf_annul", 32'(if_a.if_annul), 32'd1);
    chk("xf_wpcir", 32'(if_a.wpcir), 32'd1);
    chk("xf_bub0",  32'(if_a.id_bubble), 32'd0);
    cyc();
    #1;
    chk("xf_ds1_annul", 32'(if_b.if_annul), 32'd0);
    chk("xf_ds1_wpcir", 32'(if_b.wpcir), 32'd1);
    chk("xf_ds0_annul", 32'(if_a.if_annul), 32'd1);

    // 4: memory wait, ack on fourth cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 1, (i == 3));
      #1;
      chk($sformatf("mw_hold_%0d", i),  32'(if_b.pipe_hold), 32'd1);
      chk($sformatf("mw_wpcir_%0d", i), 32'(if_b.wpcir), 32'd0);
      chk($sformatf("mw_bub_%0d", i),   32'(if_b.id_bubble), 32'd0);
      cyc();
    end
    set_in(0, 0, 0, 0);
    #1;
    chk("mw_end_hold",  32'(if_b.pipe_hold), 32'd0);
    chk("mw_end_wpcir", 32'(if_b.wpcir), 32'd1);
    chk("mw_end_state", 32'(if_b.sched_state), 32'd0);

    // 5: MAX_WAIT=4 timeout, sticky until reset
    do_reset();
    set_in(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_pre_%0d", i), 32'(if_a.mem_timeout), 32'd0);
      chk($sformatf("to_st_%0d", i), 32'(if_a.sched_state), (i == 0) ? 32'd0 : 32'd2);
      cyc();
    end
    #1;
    chk("to_flag",  32'(if_a.mem_timeout), 32'd1);
    chk("to_state", 32'(if_a.sched_state), 32'd3);
    chk("to_hold",  32'(if_a.pipe_hold), 32'd1);
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc();
    #1;
    chk("to_stay_state", 32'(if_a.sched_state), 32'd3);
    chk("to_stay_wpcir", 32'(if_a.wpcir), 32'd0);
    set_in(0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("to_rst_state", 32'(if_a.sched_state), 32'd0);
    chk("to_rst_flag",  32'(if_a.mem_timeout), 32'd0);
    chk("to_rst_wpcir", 32'(if_a.wpcir), 32'd1);

    // 6: LOAD_LAT=3 with a 2-cycle memory wait inside the stall
    do_reset();
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(v_ld[i], 0, v_rq[i], v_ak[i]);
      #1;
      chk($sformatf("ls_wp_%0d", i),   32'(if_c.wpcir), 32'(e_wp[i]));
      chk($sformatf("ls_hold_%0d", i), 32'(if_c.pipe_hold), 32'(e_hold[i]));
      chk($sformatf("ls_bub_%0d", i),  32'(if_c.id_bubble), 32'(e_bub[i]));
      chk($sformatf("ls_st_%0d", i),   32'(if_c.sched_state), 32'(e_st[i]));
      if (!if_c.wpcir) stalls++;
      cyc();
    end
    chk("ls_total_stall", 32'(stalls), 32'd5);

    // reset in the middle of a load stall leaves no residual bubble
    do_reset();
    set_in(1, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0);
    #1;
    chk("mid_pre_state", 32'(if_c.sched_state), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_state",  32'(if_c.sched_state), 32'd0);
    chk("mid_bubble", 32'(if_c.id_bubble), 32'd0);
    chk("mid_wpcir",  32'(if_c.wpcir), 32'd1);
    cyc();
    #1;
    chk("mid_after_bubble", 32'(if_c.id_bubble), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
